// File: rtl/wired_bus_resolver_if.sv
// Signal bundle between the bus masters / diagnostics host and the wired bus resolver.
// The master side drives enables, data, mode and clear; the slave side returns resolved bus and status.
interface wired_bus_resolver_if #(
   parameter int unsigned N_DRV = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
);
   logic [N_DRV-1:0]       drv_en;
   logic [N_DRV*WIDTH-1:0] drv_data;
   logic [1:0]             mode;
   logic                   clr_status;
   logic [WIDTH-1:0]       bus_q;
   logic                   bus_valid;
   logic [WIDTH-1:0]       x_mask;
   logic [1:0]             bus_state;
   logic                   conflict_sticky;
   logic [CNT_W-1:0]       conflict_cnt;
   logic                   fault;

   modport master (
      output drv_en, drv_data, mode, clr_status,
      input  bus_q, bus_valid, x_mask, bus_state, conflict_sticky, conflict_cnt, fault
   );

   modport slave (
      input  drv_en, drv_data, mode, clr_status,
      output bus_q, bus_valid, x_mask, bus_state, conflict_sticky, conflict_cnt, fault
   );
endinterface

// File: rtl/wired_bus_resolver.sv
// Clocked N-driver shared-bus resolver: wired-OR / wired-AND / tri resolution with
// per-cycle bus classification, conflict statistics and a persistent-conflict fault latch.
module wired_bus_resolver #(
   parameter int unsigned N_DRV       = 4,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned FAULT_LIMIT = 4
) (
   input logic                clk,
   input logic                rst_n,
   wired_bus_resolver_if.slave bus
);

   localparam int unsigned EN_W  = $clog2(N_DRV + 1);
   localparam int unsigned RUN_W = 8;

   typedef enum logic [1:0] {
      MODE_WOR  = 2'd0,
      MODE_WAND = 2'd1,
      MODE_TRI  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_FLOAT    = 2'd0,
      ST_SINGLE   = 2'd1,
      ST_AGREE    = 2'd2,
      ST_CONFLICT = 2'd3
   } bus_state_e;

   logic [EN_W-1:0]  n_en;
   logic [WIDTH-1:0] or_v;
   logic [WIDTH-1:0] and_v;
   logic [WIDTH-1:0] dis;
   mode_e            mode_s;

   bus_state_e       state_q, state_nxt;
   logic             conflict;

   logic [WIDTH-1:0] bus_q_r,  bus_nxt;
   logic [WIDTH-1:0] xm_q,     xm_nxt;
   logic             valid_q,  valid_nxt;
   logic             sticky_q, sticky_nxt;
   logic [CNT_W-1:0] cnt_q,    cnt_nxt;
   logic [RUN_W-1:0] run_q,    run_nxt;
   logic             fault_q,  fault_nxt;

   assign mode_s = mode_e'(bus.mode);

   always_comb begin
      n_en  = '0;
      or_v  = '0;
      and_v = '1;
      for (int unsigned i = 0; i < N_DRV; i++) begin
         if (bus.drv_en[i]) begin
            n_en  = n_en + EN_W'(1);
            or_v  = or_v  | bus.drv_data[i*WIDTH +: WIDTH];
            and_v = and_v & bus.drv_data[i*WIDTH +: WIDTH];
         end
      end
      // With nobody driving, the AND reduction must read as 0, not all-ones.
      if (n_en == '0) begin
         and_v = '0;
      end
      dis = or_v & ~and_v;
   end

   always_comb begin
      state_nxt = ST_FLOAT;
      if (n_en == '0) begin
         state_nxt = ST_FLOAT;
      end else if (n_en == EN_W'(1)) begin
         state_nxt = ST_SINGLE;
      end else if (dis == '0) begin
         state_nxt = ST_AGREE;
      end else begin
         state_nxt = ST_CONFLICT;
      end
   end

   assign conflict = (state_nxt == ST_CONFLICT);

   always_comb begin
      sticky_nxt = sticky_q;
      cnt_nxt    = cnt_q;
      run_nxt    = '0;
      fault_nxt  = fault_q;
      if (bus.clr_status) begin
         sticky_nxt = 1'b0;
         cnt_nxt    = '0;
         run_nxt    = '0;
         fault_nxt  = 1'b0;
      end else if (conflict) begin
         sticky_nxt = 1'b1;
         if (cnt_q != '1) begin
            cnt_nxt = cnt_q + CNT_W'(1);
         end
         if (run_q != RUN_W'(FAULT_LIMIT)) begin
            run_nxt = run_q + RUN_W'(1);
         end else begin
            run_nxt = run_q;
         end
         if (run_nxt == RUN_W'(FAULT_LIMIT)) begin
            fault_nxt = 1'b1;
         end
      end
   end

   // Data outputs are gated by the fault value being registered this edge, so the
   // forcing takes effect on the same edge that fault rises.
   always_comb begin
      bus_nxt   = bus_q_r;
      xm_nxt    = '0;
      valid_nxt = (n_en != '0) && !fault_nxt;
      if (fault_nxt) begin
         bus_nxt = '0;
      end else if (n_en != '0) begin
         unique case (mode_s)
            MODE_WAND, MODE_TRI: bus_nxt = and_v;
            MODE_WOR, MODE_RSVD: bus_nxt = or_v;
            default:             bus_nxt = or_v;
         endcase
         if (mode_s == MODE_TRI) begin
            xm_nxt = dis;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FLOAT;
         bus_q_r  <= '0;
         xm_q     <= '0;
         valid_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         run_q    <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         bus_q_r  <= bus_nxt;
         xm_q     <= xm_nxt;
         valid_q  <= valid_nxt;
         sticky_q <= sticky_nxt;
         cnt_q    <= cnt_nxt;
         run_q    <= run_nxt;
         fault_q  <= fault_nxt;
      end
   end

   assign bus.bus_q           = bus_q_r;
   assign bus.bus_valid       = valid_q;
   assign bus.x_mask          = xm_q;
   assign bus.bus_state       = state_q;
   assign bus.conflict_sticky = sticky_q;
   assign bus.conflict_cnt    = cnt_q;
   assign bus.fault           = fault_q;

endmodule
